f_to_int: RTL

//  Iterative IEEE-754 single-precision to signed 32-bit integer converter (read-side counterpart of the float datapath).

---
 rtl/f_to_int.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/f_to_int.sv
// Iterative IEEE-754 single-precision to signed 32-bit integer converter.
// The significand is shifted one bit per cycle; the result is truncated toward zero.
module f_to_int #(
  parameter logic [31:0] NAN_VAL = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] in0,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        invalid
);

  typedef enum logic [1:0] {StIdle, StShift, StFinish} state_e;

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;       // 1: shift left, 0: shift right
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic [31:0] preset_q, preset_d;
  logic        flag_q, flag_d;
  logic [31:0] out_q, out_d;
  logic        invalid_q, invalid_d;
  logic        done_q, done_d;

  // Operand decode, evaluated combinationally on in0 and latched on accept.
  logic [7:0]  exp_w;
  logic [22:0] frac_w;
  logic [7:0]  diff_w;
  logic        dec_special;
  logic [31:0] dec_preset;
  logic        dec_flag;
  logic [4:0]  dec_cnt;
  logic        dec_left;

  assign exp_w  = in0[30:23];
  assign frac_w = in0[22:0];

  always_comb begin
    dec_special = 1'b0;
    dec_preset  = 32'h0;
    dec_flag    = 1'b0;
    dec_cnt     = 5'd0;
    dec_left    = 1'b0;
    diff_w      = 8'd0;
    if (exp_w == 8'd255 && frac_w != 23'd0) begin
      dec_special = 1'b1;
      dec_preset  = NAN_VAL;
      dec_flag    = 1'b1;
    end else if (in0 == 32'hCF00_0000) begin
      // -2^31 is the one representable value with e==31.
      dec_special = 1'b1;
      dec_preset  = 32'h8000_0000;
    end else if (exp_w >= 8'd158) begin
      dec_special = 1'b1;
      dec_preset  = in0[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      dec_flag    = 1'b1;
    end else if (exp_w < 8'd127) begin
      dec_special = 1'b1;
      dec_preset  = 32'h0;
    end else if (exp_w <= 8'd149) begin
      diff_w  = 8'd150 - exp_w;
      dec_cnt = diff_w[4:0];
    end else begin
      diff_w   = exp_w - 8'd150;
      dec_cnt  = diff_w[4:0];
      dec_left = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    sign_d    = sign_q;
    special_d = special_q;
    preset_d  = preset_q;
    flag_d    = flag_q;
    out_d     = out_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_d     = {8'h00, 1'b1, frac_w};
          cnt_d     = dec_cnt;
          dir_d     = dec_left;
          sign_d    = in0[31];
          special_d = dec_special;
          preset_d  = dec_preset;
          flag_d    = dec_flag;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (cnt_q == 5'd0) begin
          state_d = StFinish;
        end else begin
          mag_d = dir_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_d = cnt_q - 5'd1;
        end
      end
      StFinish: begin
        out_d     = special_q ? preset_q : (sign_q ? (~mag_q + 32'd1) : mag_q);
        invalid_d = flag_q;
        done_d    = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      mag_q     <= 32'h0;
      cnt_q     <= 5'd0;
      dir_q     <= 1'b0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      preset_q  <= 32'h0;
      flag_q    <= 1'b0;
      out_q     <= 32'h0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      sign_q    <= sign_d;
      special_q <= special_d;
      preset_q  <= preset_d;
      flag_q    <= flag_d;
      out_q     <= out_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign out     = out_q;
  assign invalid = invalid_q;

endmodule
